// File: rtl/spi_slave_regif.sv
// -----------------------------------------------------------------------------
// spi_slave_regif
//   SPI slave (CPHA=0) that bridges an external SPI master onto an on-chip
//   register bus. SCK, CS_n and MOSI are oversampled into clk; there is no
//   SCK clock domain. Frame: R/W bit, ADDR_W address bits, then DATA_W data
//   words, all MSB first. Read data is returned on MISO.
//
//   Optional feature macro: SPI_SLAVE_AUTOINC_EN
//     defined   : burst accesses, address auto-increments after every word
//     undefined : one data word per frame, then the rest is ignored
//
// Ports
//   clk, rst        system clock, asynchronous active-low reset
//   sck, cs_n, mosi asynchronous SPI inputs (synchronised here)
//   miso, miso_oe   registered SPI data out and its drive enable
//   reg_addr        register bus address
//   reg_wdata       register bus write data
//   reg_wr_en       one-clk write strobe
//   reg_rd_en       one-clk read strobe
//   reg_rdata       read data, sampled exactly 1 clk after reg_rd_en
//   busy            FSM not in IDLE
//   frame_abort     one-clk pulse when cs_n rises with a partial field
//
// Bus handshake: reg_wr_en / reg_rd_en are single-cycle strobes with no
// back-pressure; reg_addr (and reg_wdata for writes) are valid in the strobe
// cycle, and the slave must present reg_rdata in the cycle after reg_rd_en.
// -----------------------------------------------------------------------------
module spi_slave_regif #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int CPOL   = 0,
  parameter int SYNC_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_abort
);

  localparam int   HDR_W  = 1 + ADDR_W;
  localparam int   SH_W   = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int   CNT_W  = $clog2(SH_W + 1);
  localparam logic CPOL_L = (CPOL != 0);

  typedef enum logic [1:0] {IDLE, HDR, DATA, WAIT_CS} state_t;

  // Synchronisers. cs_n resets to "selected" so that a frame already in
  // progress when reset releases is recognised and skipped (WAIT_CS) instead
  // of being mistaken for a fresh cs_n fall.
  logic [SYNC_N-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic              sck_prev_q, cs_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_q  <= {SYNC_N{CPOL_L}};
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= CPOL_L;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_N-2:0], sck};
      cs_sync_q   <= {cs_sync_q[SYNC_N-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_N-2:0], mosi};
      sck_prev_q  <= sck_sync_q[SYNC_N-1];
      cs_prev_q   <= cs_sync_q[SYNC_N-1];
    end
  end

  logic sck_s, cs_s, mosi_s, lead, trail, cs_rise, cs_fall;
  assign sck_s   = sck_sync_q[SYNC_N-1] ^ CPOL_L;   // normalised: 1 = active level
  assign cs_s    = cs_sync_q[SYNC_N-1];
  assign mosi_s  = mosi_sync_q[SYNC_N-1];
  assign lead    = sck_s & ~(sck_prev_q ^ CPOL_L);
  assign trail   = ~sck_s & (sck_prev_q ^ CPOL_L);
  assign cs_rise = cs_s & ~cs_prev_q;
  assign cs_fall = ~cs_s & cs_prev_q;

  state_t            state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [SH_W-2:0]   rx_sh_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic              rw_q, wr_pend_q, load_pend_q;
  logic              miso_q, miso_oe_q, wr_en_q, rd_en_q, abort_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [SH_W-1:0] rx_word_d;
  assign rx_word_d = {rx_sh_q, mosi_s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      rw_q        <= 1'b0;
      wr_pend_q   <= 1'b0;
      load_pend_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      abort_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      // Strobe defaults; a write strobe trails its data latch by one clk.
      wr_en_q     <= wr_pend_q;
      wr_pend_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      abort_q     <= 1'b0;
      load_pend_q <= rd_en_q;
      miso_oe_q   <= ~cs_s;
      if (load_pend_q) tx_sh_q <= reg_rdata;
`ifdef SPI_SLAVE_AUTOINC_EN
      // Writes advance the address only after their strobe has used it.
      if (wr_en_q) addr_q <= addr_q + ADDR_W'(1);
`endif
      if (state_q != IDLE && cs_rise) begin
        // cs_n wins over a lead in the same clk: that bit is dropped.
        state_q   <= IDLE;
        abort_q   <= (bit_cnt_q != '0);
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            if (cs_fall)    state_q <= HDR;
            else if (!cs_s) state_q <= WAIT_CS;   // selected without a fall seen
          end
          HDR: begin
            miso_q <= 1'b0;
            if (lead) begin
              rx_sh_q <= rx_word_d[SH_W-2:0];
              if (bit_cnt_q == CNT_W'(HDR_W - 1)) begin
                addr_q    <= rx_word_d[ADDR_W-1:0];
                rw_q      <= rx_word_d[ADDR_W];
                rd_en_q   <= rx_word_d[ADDR_W];
                bit_cnt_q <= '0;
                state_q   <= DATA;
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if (trail) begin
              if (rw_q) begin
                miso_q  <= tx_sh_q[DATA_W-1];
                tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
              end else begin
                miso_q <= 1'b0;
              end
            end
            if (lead) begin
              rx_sh_q <= rx_word_d[SH_W-2:0];
              if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                bit_cnt_q <= '0;
                if (!rw_q) begin
                  wdata_q   <= rx_word_d[DATA_W-1:0];
                  wr_pend_q <= 1'b1;
                end
`ifdef SPI_SLAVE_AUTOINC_EN
                if (rw_q) begin
                  addr_q  <= addr_q + ADDR_W'(1);
                  rd_en_q <= 1'b1;
                end
`else
                state_q <= WAIT_CS;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
          end
          WAIT_CS: begin
            miso_q    <= 1'b0;
            bit_cnt_q <= '0;
            if (cs_s) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_rd_en   = rd_en_q;
  assign busy        = (state_q != IDLE);
  assign frame_abort = abort_q;

endmodule
